// File: rtl/hazard_stall_ctrl_if.sv
// Decode-side request and stall-control response bundle for hazard_stall_ctrl.
// The control block takes the slave side; decode and the bench take the master side.
interface hazard_stall_ctrl_if #(
  parameter int REG_AW = 3
);
  logic              valid_d;
  logic [REG_AW-1:0] ra_d;
  logic [REG_AW-1:0] rb_d;
  logic              use_a;
  logic              use_b;
  logic              we_d;
  logic [REG_AW-1:0] wa_d;
  logic              mem_busy;
  logic              hold;
  logic              issue;
  logic [1:0]        stall_src;
  logic              timeout;
  logic [15:0]       stall_cnt;

  modport master (
    output valid_d, ra_d, rb_d, use_a, use_b, we_d, wa_d, mem_busy,
    input  hold, issue, stall_src, timeout, stall_cnt
  );

  modport slave (
    input  valid_d, ra_d, rb_d, use_a, use_b, we_d, wa_d, mem_busy,
    output hold, issue, stall_src, timeout, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Decode stall controller: RAW scoreboard, memory-busy stall, sticky watchdog.
// Optional HOLD-cycle statistics counter built only when STALL_STATS_EN is defined.
module hazard_stall_ctrl #(
  parameter int REG_AW    = 3,
  parameter int DEPTH     = 3,
  parameter int MAX_STALL = 15
) (
  input logic               clk,
  input logic               rst,
  hazard_stall_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, RAW = 2'd1, MEM = 2'd2} src_e;

  localparam logic [8:0] MAX_S = 9'(MAX_STALL);

  logic [DEPTH-1:0]             sb_v;
  logic [DEPTH-1:0][REG_AW-1:0] sb_a;
  logic                         hit_a, hit_b, raw, hold, issue;
  src_e                         state, state_nx;
  logic [7:0]                   run_cnt;
  logic [8:0]                   run_inc;
  logic                         timeout;

  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_v[i] && sb_a[i] == bus.ra_d) hit_a = 1'b1;
      if (sb_v[i] && sb_a[i] == bus.rb_d) hit_b = 1'b1;
    end
  end

  assign raw   = bus.valid_d & ((bus.use_a & hit_a) | (bus.use_b & hit_b));
  assign hold  = ~rst & bus.valid_d & (raw | bus.mem_busy);
  assign issue = ~rst & bus.valid_d & ~hold;

  // A writer becomes visible to hazards only from the cycle after it issues,
  // which is why an instruction reading its own destination never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_v <= '0;
      sb_a <= '0;
    end else begin
      sb_v[0] <= bus.we_d & issue;
      sb_a[0] <= (bus.we_d & issue) ? bus.wa_d : '0;
      for (int i = 1; i < DEPTH; i++) begin
        sb_v[i] <= sb_v[i-1];
        sb_a[i] <= sb_a[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = RUN;
    if (bus.valid_d && bus.mem_busy) state_nx = MEM;
    else if (raw)                    state_nx = RAW;
  end

  always_comb begin
    bus.stall_src = state;
  end

  assign run_inc = {1'b0, run_cnt} + 9'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt <= '0;
      timeout <= 1'b0;
    end else if (hold) begin
      if (run_cnt != 8'hFF) run_cnt <= run_inc[7:0];
      if (run_inc >= MAX_S) timeout <= 1'b1;
    end else begin
      run_cnt <= '0;
    end
  end

`ifdef STALL_STATS_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)                                stall_cnt <= '0;
    else if (hold && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end

  assign bus.stall_cnt = stall_cnt;
`else
  assign bus.stall_cnt = 16'h0000;
`endif

  assign bus.hold    = hold;
  assign bus.issue   = issue;
  assign bus.timeout = timeout;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: RAW, MEM priority, watchdog, reset mid-stall.
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_AW(3)) bus ();

  hazard_stall_ctrl #(.REG_AW(3), .DEPTH(3), .MAX_STALL(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then let comb outputs settle.
  task automatic step(input logic r, input logic v, input logic [2:0] ra, input logic [2:0] rb,
                      input logic ua, input logic ub, input logic we, input logic [2:0] wa,
                      input logic mb);
    @(negedge clk);
    rst          = r;
    bus.valid_d  = v;
    bus.ra_d     = ra;
    bus.rb_d     = rb;
    bus.use_a    = ua;
    bus.use_b    = ub;
    bus.we_d     = we;
    bus.wa_d     = wa;
    bus.mem_busy = mb;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic wr(input logic [2:0] wa);
    step(1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, wa, 1'b0);
  endtask

  task automatic rd_a(input logic r, input logic [2:0] ra, input logic mb);
    step(r, 1'b1, ra, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, mb);
  endtask

  task automatic hi(input string tag, input logic h, input logic i);
    chk({tag, "_hold"}, 16'(bus.hold), 16'(h));
    chk({tag, "_issue"}, 16'(bus.issue), 16'(i));
  endtask

  initial begin
    rst          = 1'b1;
    bus.valid_d  = 1'b1;
    bus.ra_d     = '0;
    bus.rb_d     = '0;
    bus.use_a    = 1'b0;
    bus.use_b    = 1'b0;
    bus.we_d     = 1'b0;
    bus.wa_d     = '0;
    bus.mem_busy = 1'b1;

    // Reset with a would-be stall on the inputs
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
      hi("rst", 1'b0, 1'b0);
    end
    chk("rst_src", 16'(bus.stall_src), 16'd0);
    chk("rst_timeout", 16'(bus.timeout), 16'd0);
    chk("rst_cnt", bus.stall_cnt, 16'd0);
    bus.valid_d  = 1'b0;
    bus.mem_busy = 1'b0;
    rst          = 1'b0;

    // Dependent pair: three hold cycles, then issue
    wr(3'd5);
    hi("dep_wr", 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      rd_a(1'b0, 3'd5, 1'b0);
      hi($sformatf("dep%0d", k), k < 3, k == 3);
      if (k > 0) chk($sformatf("dep%0d_src", k), 16'(bus.stall_src), 16'd1);
    end
    idle();
    chk("dep_src_run", 16'(bus.stall_src), 16'd0);

    // Independent pair, and a self-read of the destination
    wr(3'd5);
    hi("ind_wr", 1'b0, 1'b1);
    step(1'b0, 1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    hi("ind_rd", 1'b0, 1'b1);
    step(1'b0, 1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0);
    hi("self_rd", 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) idle();

    // MEM_BUSY covering the whole RAW window: cause reads MEM only
    wr(3'd6);
    for (int k = 0; k < 5; k++) begin
      rd_a(1'b0, 3'd6, k < 4);
      hi($sformatf("mem%0d", k), k < 4, k == 4);
      if (k > 0) chk($sformatf("mem%0d_src", k), 16'(bus.stall_src), 16'd2);
    end
    idle();
    chk("mem_src_run", 16'(bus.stall_src), 16'd0);

    // MEM_BUSY for one cycle, hazard outlives it: MEM then RAW
    wr(3'd7);
    rd_a(1'b0, 3'd7, 1'b1);
    hi("mr0", 1'b1, 1'b0);
    rd_a(1'b0, 3'd7, 1'b0);
    hi("mr1", 1'b1, 1'b0);
    chk("mr1_src", 16'(bus.stall_src), 16'd2);
    rd_a(1'b0, 3'd7, 1'b0);
    hi("mr2", 1'b1, 1'b0);
    chk("mr2_src", 16'(bus.stall_src), 16'd1);
    rd_a(1'b0, 3'd7, 1'b0);
    hi("mr3", 1'b0, 1'b1);
    chk("mr3_src", 16'(bus.stall_src), 16'd1);
    idle();

    // Reset in the 2nd stall cycle drops the tracked writer
    wr(3'd5);
    rd_a(1'b0, 3'd5, 1'b0);
    hi("rs0", 1'b1, 1'b0);
    rd_a(1'b1, 3'd5, 1'b0);
    hi("rs1", 1'b0, 1'b0);
    rd_a(1'b0, 3'd5, 1'b0);
    hi("rs2", 1'b0, 1'b1);
    chk("rs2_src", 16'(bus.stall_src), 16'd0);

    // Watchdog: 20 MEM_BUSY cycles from a fresh reset
    step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
      chk($sformatf("wd%0d_hold", k), 16'(bus.hold), 16'd1);
      chk($sformatf("wd%0d_timeout", k), 16'(bus.timeout), 16'(k >= 15));
    end
    idle();
    hi("wd_end", 1'b0, 1'b0);
    chk("wd_timeout_held", 16'(bus.timeout), 16'd1);
`ifdef STALL_STATS_EN
    chk("wd_stall_cnt", bus.stall_cnt, 16'd20);
`else
    chk("wd_stall_cnt", bus.stall_cnt, 16'd0);
`endif
    idle();
    chk("wd_timeout_sticky", 16'(bus.timeout), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
